// File: rtl/reg_file_pkg.sv
// Shared constants, address-width helper and read-request type for the
// scoreboarded register file.
package reg_file_pkg;

  localparam int DEFAULT_WIDTH = 16;
  localparam int DEFAULT_NREGS = 8;
  localparam int MAX_NREGS     = 64;
  localparam int MAX_AW        = 6;

  // Ceiling log2 with a floor of 1, so a 2-entry bank still gets one address bit.
  function automatic int addr_width(input int nregs);
    int w;
    w = 1;
    while ((1 << w) < nregs) w = w + 1;
    return w;
  endfunction

  // Address is sized for the largest legal bank; narrower banks zero-extend.
  typedef struct packed {
    logic              en;
    logic [MAX_AW-1:0] addr;
  } rd_req_t;

endpackage

// File: rtl/reg_file_rd_port.sv
// One registered read port: index mux, pending-based valid, out-of-range
// squash, and (under REG_FILE_BYPASS_EN) same-cycle write forwarding.
module reg_file_rd_port
  import reg_file_pkg::*;
#(
  parameter int   WIDTH = DEFAULT_WIDTH,
  parameter int   NREGS = DEFAULT_NREGS,
  localparam int  AW    = addr_width(NREGS)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NREGS-1:0][WIDTH-1:0]  mem,
  input  logic [NREGS-1:0]             pend,
`ifdef REG_FILE_BYPASS_EN
  input  logic                         wr_en,
  input  logic [AW-1:0]                wr_addr,
  input  logic [WIDTH-1:0]             wr_data,
`endif
  input  rd_req_t                      req,
  output logic [WIDTH-1:0]             rd_data,
  output logic                         rd_valid
);

  localparam logic [MAX_AW:0] NREGS_LIM = (MAX_AW+1)'(NREGS);

  logic [AW-1:0]    idx;
  logic             in_range;
  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;

  always_comb begin
    idx      = req.addr[AW-1:0];
    in_range = ({1'b0, req.addr} < NREGS_LIM);
    data_d   = data_q;
    valid_d  = 1'b0;
    if (req.en) begin
      if (in_range) begin
        data_d  = mem[idx];
        valid_d = ~pend[idx];
`ifdef REG_FILE_BYPASS_EN
        // wr_en arrives already qualified as an in-range write.
        if (wr_en && (wr_addr == idx)) begin
          data_d  = wr_data;
          valid_d = 1'b1;
        end
`endif
      end else begin
        data_d = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign rd_data  = data_q;
  assign rd_valid = valid_q;

endmodule

// File: rtl/reg_file_sb.sv
// NREGS x WIDTH register file with one write port, two registered read ports
// and per-register pending bits. Define REG_FILE_BYPASS_EN for write-to-read forwarding.
module reg_file_sb
  import reg_file_pkg::*;
#(
  parameter int   WIDTH = DEFAULT_WIDTH,
  parameter int   NREGS = DEFAULT_NREGS,
  localparam int  AW    = addr_width(NREGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              rsv_en,
  input  logic [AW-1:0]     rsv_addr,
  input  logic              rd0_en,
  input  logic [AW-1:0]     rd0_addr,
  output logic [WIDTH-1:0]  rd0_data,
  output logic              rd0_valid,
  input  logic              rd1_en,
  input  logic [AW-1:0]     rd1_addr,
  output logic [WIDTH-1:0]  rd1_data,
  output logic              rd1_valid,
  output logic [NREGS-1:0]  pend
);

  localparam logic [AW:0] NREGS_LIM = (AW+1)'(NREGS);

  logic [NREGS-1:0][WIDTH-1:0] mem_q, mem_d;
  logic [NREGS-1:0]            pend_q, pend_d;
  logic                        wr_hit, rsv_hit;
  rd_req_t                     rd0_req, rd1_req;

  // NOTE: always_comb uses blocking '=' so later statements see earlier ones;
  // that ordering is what lets a same-cycle reserve override the write's clear.
  always_comb begin
    wr_hit  = wr_en  && ({1'b0, wr_addr}  < NREGS_LIM);
    rsv_hit = rsv_en && ({1'b0, rsv_addr} < NREGS_LIM);
    mem_d   = mem_q;
    pend_d  = pend_q;
    if (wr_hit) begin
      mem_d[wr_addr]  = wr_data;
      pend_d[wr_addr] = 1'b0;
    end
    if (rsv_hit) begin
      pend_d[rsv_addr] = 1'b1;
    end
  end

  // NOTE: the bank is small and architecturally defined as zero after reset,
  // so it lives in resettable flops rather than an inferred RAM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q  <= '0;
      pend_q <= '0;
    end else begin
      mem_q  <= mem_d;
      pend_q <= pend_d;
    end
  end

  assign pend = pend_q;

  always_comb begin
    rd0_req = '{en: rd0_en, addr: MAX_AW'(rd0_addr)};
    rd1_req = '{en: rd1_en, addr: MAX_AW'(rd1_addr)};
  end

  reg_file_rd_port #(.WIDTH(WIDTH), .NREGS(NREGS)) u_rd0 (
    .clk      (clk),
    .rst_n    (rst_n),
    .mem      (mem_q),
    .pend     (pend_q),
`ifdef REG_FILE_BYPASS_EN
    .wr_en    (wr_hit),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
`endif
    .req      (rd0_req),
    .rd_data  (rd0_data),
    .rd_valid (rd0_valid)
  );

  reg_file_rd_port #(.WIDTH(WIDTH), .NREGS(NREGS)) u_rd1 (
    .clk      (clk),
    .rst_n    (rst_n),
    .mem      (mem_q),
    .pend     (pend_q),
`ifdef REG_FILE_BYPASS_EN
    .wr_en    (wr_hit),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
`endif
    .req      (rd1_req),
    .rd_data  (rd1_data),
    .rd_valid (rd1_valid)
  );

endmodule

// File: tb/tb_reg_file_sb.sv
// Bench for reg_file_sb: an 8-entry and a 6-entry instance share stimulus and
// are compared each cycle against an array-based model of the register file.
module tb_reg_file_sb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_en, rsv_en, rd0_en, rd1_en;
  logic [2:0]  wr_addr, rsv_addr, rd0_addr, rd1_addr;
  logic [15:0] wr_data;

  logic [15:0] a_rd0_data, a_rd1_data, b_rd0_data, b_rd1_data;
  logic        a_rd0_valid, a_rd1_valid, b_rd0_valid, b_rd1_valid;
  logic [7:0]  a_pend;
  logic [5:0]  b_pend;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  reg_file_sb #(.WIDTH(16), .NREGS(8)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .rd0_en(rd0_en), .rd0_addr(rd0_addr), .rd0_data(a_rd0_data), .rd0_valid(a_rd0_valid),
    .rd1_en(rd1_en), .rd1_addr(rd1_addr), .rd1_data(a_rd1_data), .rd1_valid(a_rd1_valid),
    .pend(a_pend)
  );

  reg_file_sb #(.WIDTH(16), .NREGS(6)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .rd0_en(rd0_en), .rd0_addr(rd0_addr), .rd0_data(b_rd0_data), .rd0_valid(b_rd0_valid),
    .rd1_en(rd1_en), .rd1_addr(rd1_addr), .rd1_data(b_rd1_data), .rd1_valid(b_rd1_valid),
    .pend(b_pend)
  );

  // Reference model: index 0 is the 8-entry bank, index 1 the 6-entry bank.
  logic [15:0] m_mem   [2][8];
  logic [7:0]  m_pend  [2];
  logic [15:0] e_data  [2][2];
  logic        e_valid [2][2];

  function automatic int nregs_of(input int k);
    return (k == 0) ? 8 : 6;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_pend[k] = '0;
      for (int i = 0; i < 8; i++) m_mem[k][i] = '0;
      for (int p = 0; p < 2; p++) begin
        e_data[k][p]  = '0;
        e_valid[k][p] = 1'b0;
      end
    end
  endtask

  // Applies one clock edge worth of behaviour using the pre-edge model state.
  task automatic model_step();
    logic       en [2];
    logic [2:0] ad [2];
    int         n;
    en[0] = rd0_en; ad[0] = rd0_addr;
    en[1] = rd1_en; ad[1] = rd1_addr;
    for (int k = 0; k < 2; k++) begin
      n = nregs_of(k);
      for (int p = 0; p < 2; p++) begin
        if (!en[p]) begin
          e_valid[k][p] = 1'b0;
        end else if (int'(ad[p]) < n) begin
          e_data[k][p]  = m_mem[k][ad[p]];
          e_valid[k][p] = !m_pend[k][ad[p]];
`ifdef REG_FILE_BYPASS_EN
          if (wr_en && wr_addr == ad[p]) begin
            e_data[k][p]  = wr_data;
            e_valid[k][p] = 1'b1;
          end
`endif
        end else begin
          e_data[k][p]  = '0;
          e_valid[k][p] = 1'b0;
        end
      end
      if (wr_en && int'(wr_addr) < n) begin
        m_mem[k][wr_addr]  = wr_data;
        m_pend[k][wr_addr] = 1'b0;
      end
      if (rsv_en && int'(rsv_addr) < n) m_pend[k][rsv_addr] = 1'b1;
    end
  endtask

  task automatic compare_all();
    check("a.rd0_data",  a_rd0_data,  e_data[0][0]);
    check("a.rd0_valid", a_rd0_valid, e_valid[0][0]);
    check("a.rd1_data",  a_rd1_data,  e_data[0][1]);
    check("a.rd1_valid", a_rd1_valid, e_valid[0][1]);
    check("a.pend",      a_pend,      m_pend[0]);
    check("b.rd0_data",  b_rd0_data,  e_data[1][0]);
    check("b.rd0_valid", b_rd0_valid, e_valid[1][0]);
    check("b.rd1_data",  b_rd1_data,  e_data[1][1]);
    check("b.rd1_valid", b_rd1_valid, e_valid[1][1]);
    check("b.pend",      {2'b00, b_pend}, m_pend[1]);
  endtask

  task automatic idle();
    wr_en = 1'b0; rsv_en = 1'b0; rd0_en = 1'b0; rd1_en = 1'b0;
  endtask

  // Inputs are set between edges; outputs are sampled 1 time unit after the edge.
  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    wr_addr = '0; rsv_addr = '0; rd0_addr = '0; rd1_addr = '0; wr_data = '0;
    model_reset();
    #12;
    check("reset rd0_data",  a_rd0_data, 16'h0000);
    check("reset rd0_valid", a_rd0_valid, 1'b0);
    check("reset pend",      a_pend, 8'h00);
    rst_n = 1'b1;

    // Mid-run reset after writing r3.
    wr_en = 1'b1; wr_addr = 3'd3; wr_data = 16'hABCD;
    cycle();
    idle(); rd0_en = 1'b1; rd0_addr = 3'd3; rsv_en = 1'b1; rsv_addr = 3'd6;
    cycle();
    check("pre-reset r3", a_rd0_data, 16'hABCD);
    idle();
    rst_n = 1'b0;
    #1;
    model_reset();
    check("mid reset rd0_data",  a_rd0_data, 16'h0000);
    check("mid reset rd0_valid", a_rd0_valid, 1'b0);
    check("mid reset pend",      a_pend, 8'h00);
    #1;
    rst_n = 1'b1;
    rd0_en = 1'b1; rd0_addr = 3'd3;
    cycle();
    check("post-reset r3 data",  a_rd0_data, 16'h0000);
    check("post-reset r3 valid", a_rd0_valid, 1'b1);

    // Plain write then read, then hold.
    idle(); wr_en = 1'b1; wr_addr = 3'd2; wr_data = 16'h1234;
    cycle();
    idle(); rd0_en = 1'b1; rd0_addr = 3'd2;
    cycle();
    check("r2 data",  a_rd0_data, 16'h1234);
    check("r2 valid", a_rd0_valid, 1'b1);
    idle();
    cycle();
    check("r2 hold data",  a_rd0_data, 16'h1234);
    check("r2 idle valid", a_rd0_valid, 1'b0);

    // Reserve, stalled read, writeback, good read.
    rsv_en = 1'b1; rsv_addr = 3'd5;
    cycle();
    idle(); rd1_en = 1'b1; rd1_addr = 3'd5;
    cycle();
    check("r5 reserved valid", a_rd1_valid, 1'b0);
    check("r5 pend set",       a_pend[5], 1'b1);
    idle(); wr_en = 1'b1; wr_addr = 3'd5; wr_data = 16'h00FF;
    cycle();
    idle(); rd1_en = 1'b1; rd1_addr = 3'd5;
    cycle();
    check("r5 data",      a_rd1_data, 16'h00FF);
    check("r5 valid",     a_rd1_valid, 1'b1);
    check("r5 pend clr",  a_pend[5], 1'b0);

    // Same-cycle write and read of r4.
    idle(); wr_en = 1'b1; wr_addr = 3'd4; wr_data = 16'h0001;
    cycle();
    rd0_en = 1'b1; rd0_addr = 3'd4; wr_data = 16'hBEEF;
    cycle();
`ifdef REG_FILE_BYPASS_EN
    check("r4 fwd data", a_rd0_data, 16'hBEEF);
`else
    check("r4 old data", a_rd0_data, 16'h0001);
`endif
    check("r4 valid", a_rd0_valid, 1'b1);

    // Reserve wins over a same-cycle write.
    idle(); wr_en = 1'b1; wr_addr = 3'd1; wr_data = 16'h5A5A; rsv_en = 1'b1; rsv_addr = 3'd1;
    cycle();
    check("r1 pend after rsv+wr", a_pend[1], 1'b1);
    idle(); rd0_en = 1'b1; rd0_addr = 3'd1;
    cycle();
    check("r1 stalled valid", a_rd0_valid, 1'b0);
    idle(); wr_en = 1'b1; wr_addr = 3'd1; wr_data = 16'h0C0C;
    cycle();
    idle(); rd0_en = 1'b1; rd0_addr = 3'd1;
    cycle();
    check("r1 released valid", a_rd0_valid, 1'b1);
    check("r1 released data",  a_rd0_data, 16'h0C0C);

    // Out-of-range on the 6-entry bank (index 7 is legal on the 8-entry bank).
    idle(); wr_en = 1'b1; wr_addr = 3'd7; wr_data = 16'hFFFF; rsv_en = 1'b1; rsv_addr = 3'd6;
    cycle();
    idle(); rd0_en = 1'b1; rd0_addr = 3'd7;
    cycle();
    check("b oob data",  b_rd0_data, 16'h0000);
    check("b oob valid", b_rd0_valid, 1'b0);
    check("a r7 data",   a_rd0_data, 16'hFFFF);
    for (int i = 0; i < 6; i++) begin
      idle(); rd0_en = 1'b1; rd0_addr = 3'(i); rd1_en = 1'b1; rd1_addr = 3'(5 - i);
      cycle();
    end
    // Both ports on the same index.
    idle(); rd0_en = 1'b1; rd1_en = 1'b1; rd0_addr = 3'd2; rd1_addr = 3'd2;
    cycle();
    check("dual r2 port1", a_rd1_data, 16'h1234);

    // Randomized traffic.
    for (int it = 0; it < 400; it++) begin
      wr_en    = ($urandom_range(0, 2) == 0);
      rsv_en   = ($urandom_range(0, 3) == 0);
      rd0_en   = ($urandom_range(0, 1) == 1);
      rd1_en   = ($urandom_range(0, 1) == 1);
      wr_addr  = 3'($urandom_range(0, 7));
      rsv_addr = 3'($urandom_range(0, 7));
      rd0_addr = 3'($urandom_range(0, 7));
      rd1_addr = ($urandom_range(0, 3) == 0) ? wr_addr : 3'($urandom_range(0, 7));
      wr_data  = 16'($urandom);
      cycle();
    end

    idle();
    cycle();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
Parametrised successor to the single 16-bit register: a bank of NREGS registers of WIDTH bits each.
- One synchronous write port, two registered read ports.
- Per-register pending (scoreboard) bits, so the datapath controller can reserve a destination register and stall consumers until writeback.
- Sits between the decode stage (reserve, read) and the writeback stage (write) of the processor datapath.

Parameters:
- WIDTH, 16, data width of each register.
- NREGS, 8, number of registers; 2..64, need not be a power of two.
- AW, $clog2(NREGS), address width; localparam, derived, not overridable.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset; asynchronous, active-low.
- wr_en  input  1  writeback strobe.
- wr_addr  input  AW  writeback register index.
- wr_data  input  WIDTH  writeback data.
- rsv_en  input  1  reserve strobe (marks a destination as pending).
- rsv_addr  input  AW  register index to reserve.
- rd0_en  input  1  read request, port 0.
- rd0_addr  input  AW  read index, port 0.
- rd0_data  output  WIDTH  read data, port 0 (registered).
- rd0_valid  output  1  port 0 data usable (registered).
- rd1_en, rd1_addr, rd1_data, rd1_valid: same as port 0, for port 1.
- pend  output  NREGS  current pending bit per register.

Behaviour:
- Reset (rst_n low, asynchronous): all registers 0; pend 0; rd0_data, rd1_data 0; rd0_valid, rd1_valid 0. Mid-operation reset discards in-flight reads and all reservations.
- Write: at a posedge with wr_en=1 and wr_addr<NREGS, mem[wr_addr] <= wr_data and pend[wr_addr] <= 0.
- Reserve: at a posedge with rsv_en=1 and rsv_addr<NREGS, pend[rsv_addr] <= 1.
- Reserve and write to the same index in the same cycle: the write updates mem, but pend ends at 1 (reserve wins, because a new producer has been issued).
- Read latency is 1 cycle.
  - At a posedge with rdX_en=1: rdX_data <= mem[rdX_addr] and rdX_valid <= ~pend[rdX_addr], both using pre-edge state.
  - When rdX_en=0: rdX_data holds its value and rdX_valid <= 0.
- Out-of-range index (index >= NREGS):
  - Writes and reserves are ignored.
  - Reads give rdX_data <= 0 and rdX_valid <= 0.
- Both read ports may address the same register, and each other's index, in any cycle; the ports are fully independent.
- A reserve in the same cycle as a read of that index does not affect that read; it only affects reads on later cycles.
- pend is a direct register output, with no combinational path from inputs.

Optional Feature:
- REG_FILE_BYPASS_EN, defined: write-to-read forwarding. If wr_en=1, rdX_en=1 and wr_addr==rdX_addr (in range) in the same cycle, then rdX_data <= wr_data and rdX_valid <= 1, regardless of the pre-edge pend value.
- Not defined: a read in the same cycle as a write to that index returns the old mem value, with valid = ~pend (pre-edge). The consumer retries on the next cycle.

Decomposition:
- Package reg_file_pkg:
  - default WIDTH and NREGS constants;
  - AW computation function;
  - rd_req struct typedef {en, addr}.
- One natural sub-module, reg_file_rd_port: the registered read mux plus the valid/bypass logic. Instantiated twice; it takes mem, pend and the write-port signals as inputs.

Test Plan:
- Reset with rst_n=0 mid-run after writing 16'hABCD to r3 -> rd0_data=0, rd0_valid=0, pend=0, and reading r3 afterwards returns 0 with valid=1.
- Write r2=16'h1234, then next cycle rd0_en=1, rd0_addr=2 -> one cycle later rd0_data=16'h1234 and rd0_valid=1; the following cycle with rd0_en=0 gives rd0_valid=0 and rd0_data held at 16'h1234.
- rsv r5, then read r5 -> rd1_valid=0 and pend[5]=1. Then wr r5=16'h00FF, then read -> rd1_data=16'h00FF, rd1_valid=1, pend[5]=0.
- Same-cycle wr r4=16'hBEEF and rd0 r4, with r4 previously 16'h0001:
  - with REG_FILE_BYPASS_EN -> rd0_data=16'hBEEF, valid=1;
  - without -> rd0_data=16'h0001.
- Same-cycle rsv and wr on r1=16'h5A5A -> pend[1]=1, and a subsequent read gives rd0_valid=0; a later wr clears it.
- NREGS=6: wr addr 7 = 16'hFFFF, then read addr 7 -> rd0_data=0, rd0_valid=0, and registers 0..5 unchanged.
